uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 106 ++++++++++
 tb/tb_uart_receiver.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 LSB-first serial receiver with valid/ready output,
// framing-error and overrun pulses.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_sync;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    assign busy = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_sync)
                        state <= START;
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? IDLE : DATA;
                    end else
                        cnt <= cnt + 1'b1;
                end
                DATA: begin
                    if (cnt == LAST) begin
                        shift[bit_idx] <= rx_sync;
                        cnt            <= '0;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end else
                        cnt <= cnt + 1'b1;
                end
                STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            state <= IDLE;
                            // a word can load in the same cycle the held one is consumed
                            if (!rx_valid || rx_ready) begin
                                rx_byte  <= shift;
                                rx_valid <= 1'b1;
                            end else
                                overrun <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end else
                        cnt <= cnt + 1'b1;
                end
                WAIT_IDLE: begin
                    if (rx_sync)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames with a scoreboard of expected words/pulses
// popped by an independent output monitor.
module tb_uart_receiver;
    localparam int CPB = 87;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] data;
    } evt_t;

    localparam logic [1:0] K_WORD = 2'd0;
    localparam logic [1:0] K_FE   = 2'd1;
    localparam logic [1:0] K_OV   = 2'd2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int   passed = 0;
    int   total = 0;
    evt_t exp_q[$];

    logic       v_prev = 1'b0;
    logic       acc_prev = 1'b0;
    logic       fe_prev = 1'b0;
    logic       ov_prev = 1'b0;
    logic [7:0] byte_prev = 8'h00;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    task automatic check_evt(input logic [1:0] k, input logic [7:0] d);
        evt_t e;
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got kind %0d data %h, nothing expected", k, d);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind == k && (k != K_WORD || e.data == d)) passed++;
        else $display("FAIL event: got kind %0d data %h expected kind %0d data %h", k, d, e.kind, e.data);
    endtask

    task automatic expect_evt(input logic [1:0] k, input logic [7:0] d);
        evt_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic bit_time(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop);
        rx = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            v_prev   = 1'b0;
            acc_prev = 1'b0;
            fe_prev  = 1'b0;
            ov_prev  = 1'b0;
        end else begin
            if (frame_err && overrun) check("fe_ov_together", 8'd1, 8'd0);
            if (frame_err && fe_prev) check("fe_width", 8'd2, 8'd1);
            if (overrun && ov_prev) check("ov_width", 8'd2, 8'd1);
            if (frame_err) check_evt(K_FE, 8'h00);
            if (overrun) check_evt(K_OV, 8'h00);
            if (rx_valid && (!v_prev || acc_prev)) begin
                check_evt(K_WORD, rx_byte);
                check("busy_at_delivery", {7'd0, busy}, 8'd0);
            end else if (rx_valid && v_prev)
                check("byte_stable", rx_byte, byte_prev);
            v_prev    = rx_valid;
            acc_prev  = rx_valid && rx_ready;
            fe_prev   = frame_err;
            ov_prev   = overrun;
            byte_prev = rx_byte;
        end
    end

    initial begin
        #1;
        check("rst_byte", rx_byte, 8'h00);
        check("rst_valid", {7'd0, rx_valid}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_pulses", {6'd0, frame_err, overrun}, 8'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // single word, consumer ready
        expect_evt(K_WORD, 8'h41);
        send(8'h41, 1'b1);
        repeat (CPB) @(negedge clk);
        check("valid_one_cycle", {7'd0, rx_valid}, 8'd0);

        // short low glitch must be rejected from START
        rx = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_busy", {7'd0, busy}, 8'd1);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        check("glitch_idle", {7'd0, busy}, 8'd0);

        // framing error, then recovery
        expect_evt(K_FE, 8'h00);
        send(8'h5A, 1'b0);
        repeat (CPB) @(negedge clk);
        check("fe_idle", {7'd0, busy}, 8'd0);
        expect_evt(K_WORD, 8'h5A);
        send(8'h5A, 1'b1);
        repeat (CPB) @(negedge clk);

        // overrun with consumer stalled
        rx_ready = 1'b0;
        expect_evt(K_WORD, 8'hA5);
        send(8'hA5, 1'b1);
        expect_evt(K_OV, 8'h00);
        send(8'h3C, 1'b1);
        repeat (CPB) @(negedge clk);
        check("ov_hold_byte", rx_byte, 8'hA5);
        check("ov_hold_valid", {7'd0, rx_valid}, 8'd1);
        rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ov_drain", {7'd0, rx_valid}, 8'd0);

        // asynchronous reset in the middle of bit 3 of 0x96
        bit_time(1'b0);
        for (int i = 0; i < 3; i++) bit_time(((8'h96 >> i) & 8'h01) != 0);
        rx = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        check("mid_busy", {7'd0, busy}, 8'd1);
        #2;
        rst_n = 1'b0;
        rx = 1'b1;
        #1;
        check("mid_rst_byte", rx_byte, 8'h00);
        check("mid_rst_busy", {7'd0, busy}, 8'd0);
        check("mid_rst_valid", {7'd0, rx_valid}, 8'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (CPB) @(negedge clk);
        expect_evt(K_WORD, 8'hFF);
        send(8'hFF, 1'b1);
        repeat (CPB) @(negedge clk);

        // loopback-style back-to-back frames at the same bit period
        expect_evt(K_WORD, 8'h00);
        expect_evt(K_WORD, 8'hFF);
        expect_evt(K_WORD, 8'h41);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h41, 1'b1);
        repeat (2 * CPB) @(negedge clk);

        check("scoreboard_empty", 8'(exp_q.size()), 8'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
